// File: rtl/quant_pkg.sv
// Shared constants and helpers for the requantization pipeline.
//   ACC_W, OUT_W    : accumulator and output lane widths
//   PROD_W, RND_W   : full product width and rounding-add width (one guard bit)
//   SUM_W           : width of the zero-point add before the final int8 clamp
//   sat32 / clamp8  : saturation helpers used by the per-lane datapath
package quant_pkg;

  localparam int ACC_W       = 32;
  localparam int OUT_W       = 8;
  localparam int PROD_W      = 2 * ACC_W;
  localparam int RND_W       = PROD_W + 1;
  localparam int SUM_W       = 34;
  localparam int REQ_LATENCY = 4;

  localparam logic signed [OUT_W-1:0] INT8_MIN = -8'sd128;
  localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sd127;

  // Saturate a rounded 65-bit value into int32. The value fits exactly when
  // bits [64:31] are all copies of the sign bit.
  function automatic logic signed [ACC_W-1:0] sat32(input logic signed [RND_W-1:0] v);
    logic [RND_W-ACC_W:0] top;
    top = v[RND_W-1:ACC_W-1];
    if ((&top) || !(|top)) begin
      return signed'(v[ACC_W-1:0]);
    end else if (v[RND_W-1]) begin
      return signed'(32'h8000_0000);
    end else begin
      return signed'(32'h7fff_ffff);
    end
  endfunction

  // Clamp a zero-point-adjusted sum into [lo, 127].
  function automatic logic signed [OUT_W-1:0] clamp8(input logic signed [SUM_W-1:0] s,
                                                     input logic signed [OUT_W-1:0] lo);
    logic signed [SUM_W-1:0] lo_ext;
    logic signed [SUM_W-1:0] hi_ext;
    lo_ext = {{(SUM_W-OUT_W){lo[OUT_W-1]}}, lo};
    hi_ext = {{(SUM_W-OUT_W){1'b0}}, INT8_MAX};
    if (s < lo_ext) begin
      return lo;
    end else if (s > hi_ext) begin
      return INT8_MAX;
    end else begin
      return signed'(s[OUT_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-lane requantization datapath covering stages S2..S4.
//   clk, rst_n : clock and async active-low reset
//   en         : pipeline advance; all registers hold when low
//   acc_s1     : S1 accumulator for this lane
//   mult_s1    : S1 multiplier (shared by all lanes)
//   shift_s2   : right-shift amount aligned with the S2 product register
//   zp_s3      : output zero point aligned with the S3 rounded register
//   relu_s3    : fused-ReLU select aligned with S3
//   res        : registered int8 result (S4)
module requant_lane
  import quant_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  acc_s1,
  input  logic signed [ACC_W-1:0]  mult_s1,
  input  logic [5:0]               shift_s2,
  input  logic signed [OUT_W-1:0]  zp_s3,
  input  logic                     relu_s3,
  output logic signed [OUT_W-1:0]  res
);

  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  r_q;

  logic signed [RND_W-1:0]  prod_ext;
  logic signed [RND_W-1:0]  rnd_bias;
  logic signed [RND_W-1:0]  rnd_sum;
  logic signed [RND_W-1:0]  shifted;
  logic signed [SUM_W-1:0]  sum;
  logic signed [OUT_W-1:0]  lo;

  // The extra guard bit keeps prod + 2^62 from overflowing at shift=63.
  // With shift=0 the bias is zero, so the same path yields r = prod.
  always_comb begin
    prod_ext = {prod_q[PROD_W-1], prod_q};
    rnd_bias = '0;
    if (shift_s2 != 6'd0) begin
      rnd_bias = RND_W'(1) << (shift_s2 - 6'd1);
    end
    rnd_sum = prod_ext + rnd_bias;
    shifted = rnd_sum >>> shift_s2;
  end

  always_comb begin
    sum = {{(SUM_W-ACC_W){r_q[ACC_W-1]}}, r_q} + {{(SUM_W-OUT_W){zp_s3[OUT_W-1]}}, zp_s3};
    lo  = relu_s3 ? zp_s3 : INT8_MIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      r_q    <= '0;
      res    <= '0;
    end else if (en) begin
      prod_q <= acc_s1 * mult_s1;
      r_q    <= sat32(shifted);
      res    <= clamp8(sum, lo);
    end
  end

endmodule

// File: rtl/requant_pipe.sv
// Per-layer requantization stage: LANES int32 accumulators per beat become
// int8 activations, out = clamp(round(acc*mult / 2^shift) + zp).
// Fixed 4-stage pipeline; layer parameters travel alongside each beat.
//   clk, rst_n    : clock and async active-low reset
//   in_valid/in_ready, in_acc, in_last : input beat stream
//   mult_scalar, shift_scalar, zp_out, relu_en : layer params, sampled on accept
//   out_valid/out_ready, out_data, out_last    : output beat stream
module requant_pipe #(
  parameter int LANES = 8,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*ACC_W-1:0] in_acc,
  input  logic                 in_last,
  input  logic [31:0]          mult_scalar,
  input  logic [5:0]           shift_scalar,
  input  logic [7:0]           zp_out,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*8-1:0]   out_data,
  output logic                 out_last
);

  import quant_pkg::*;

  // The whole pipe moves as one; bubbles are carried, not squeezed out.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && rst_n;

  logic [LANES*ACC_W-1:0] acc1;
  logic [31:0]            mult1;
  logic [5:0]             shift1, shift2;
  logic [7:0]             zp1, zp2, zp3;
  logic                   relu1, relu2, relu3;
  logic                   v1, v2, v3;
  logic                   last1, last2, last3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1      <= '0;
      mult1     <= '0;
      shift1    <= '0;
      shift2    <= '0;
      zp1       <= '0;
      zp2       <= '0;
      zp3       <= '0;
      relu1     <= 1'b0;
      relu2     <= 1'b0;
      relu3     <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      last3     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      acc1      <= in_acc;
      mult1     <= mult_scalar;
      shift1    <= shift_scalar;
      zp1       <= zp_out;
      relu1     <= relu_en;
      v1        <= in_valid && in_ready;
      last1     <= in_last;

      shift2    <= shift1;
      zp2       <= zp1;
      relu2     <= relu1;
      v2        <= v1;
      last2     <= last1;

      zp3       <= zp2;
      relu3     <= relu2;
      v3        <= v2;
      last3     <= last2;

      out_valid <= v3;
      out_last  <= last3;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .acc_s1   (acc1[i*ACC_W +: ACC_W]),
      .mult_s1  (mult1),
      .shift_s2 (shift2),
      .zp_s3    (zp3),
      .relu_s3  (relu3),
      .res      (out_data[i*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_requant_pipe.sv
module tb_requant_pipe;

  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int LAT   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_acc;
  logic                   in_last;
  logic [31:0]            mult_scalar;
  logic [5:0]             shift_scalar;
  logic [7:0]             zp_out;
  logic                   relu_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*8-1:0]     out_data;
  logic                   out_last;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  requant_pipe #(.LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_acc       (in_acc),
    .in_last      (in_last),
    .mult_scalar  (mult_scalar),
    .shift_scalar (shift_scalar),
    .zp_out       (zp_out),
    .relu_en      (relu_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  typedef struct {
    string              name;
    logic signed [31:0] acc;
    logic signed [31:0] mult;
    logic [5:0]         shift;
    logic signed [7:0]  zp;
    logic               relu;
    logic signed [7:0]  expv;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // per-beat stimulus for streaming sequences
  logic signed [31:0] b_acc   [16][LANES];
  logic signed [31:0] b_mult  [16];
  logic [5:0]         b_shift [16];
  logic signed [7:0]  b_zp    [16];
  logic               b_relu  [16];
  logic [63:0]        b_exp   [16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Golden model in plain wide arithmetic.
  function automatic logic signed [7:0] model(input logic signed [31:0] acc,
                                              input logic signed [31:0] mult,
                                              input logic [5:0] sh,
                                              input logic signed [7:0] zp,
                                              input logic relu);
    longint p, r, s, lo;
    logic signed [127:0] w;
    p = longint'(acc) * longint'(mult);
    w = p;
    if (sh != 6'd0) w = (w + (128'sd1 <<< (sh - 1))) >>> sh;
    if (w > 128'sd2147483647) r = 64'sd2147483647;
    else if (w < -128'sd2147483648) r = -64'sd2147483648;
    else r = longint'(w);
    s  = r + longint'(zp);
    lo = relu ? longint'(zp) : -64'sd128;
    if (s < lo) s = lo;
    if (s > 127) s = 127;
    return 8'(s);
  endfunction

  task automatic send_single(input string nm, input logic signed [31:0] acc,
                             input logic signed [31:0] mult, input logic [5:0] sh,
                             input logic signed [7:0] zp, input logic relu,
                             input logic signed [7:0] expv);
    int lat;
    bit got;
    @(negedge clk);
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_acc       = {LANES{acc}};
    mult_scalar  = mult;
    shift_scalar = sh;
    zp_out       = zp;
    relu_en      = relu;
    in_last      = 1'b1;
    #1 check({nm, "_inready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    check({nm, "_lat"}, 64'(lat), 64'(LAT));
    check({nm, "_data"}, out_data, {LANES{expv}});
    check({nm, "_last"}, 64'(out_last), 64'd1);
  endtask

  task automatic run_stream(input string nm, input int n, input bit bp);
    int sent, rcvd, cyc, extra;
    logic [3:0]  pat;
    logic [63:0] prev_data;
    logic        prev_last, prev_stall;
    pat = 4'b1001;
    sent = 0; rcvd = 0; cyc = 0; extra = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (rcvd < n && cyc < 300) begin
      @(negedge clk);
      if (prev_stall) begin
        check({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({nm, "_stall_data"}, out_data, prev_data);
        check({nm, "_stall_last"}, 64'(out_last), 64'(prev_last));
      end
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (sent < n) begin
        in_valid = 1'b1;
        for (int l = 0; l < LANES; l++) in_acc[l*ACC_W +: ACC_W] = b_acc[sent][l];
        mult_scalar  = b_mult[sent];
        shift_scalar = b_shift[sent];
        zp_out       = b_zp[sent];
        relu_en      = b_relu[sent];
        in_last      = (sent == n - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) check({nm, "_stall_inready"}, 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        check($sformatf("%s_data%0d", nm, rcvd), out_data, b_exp[rcvd]);
        check($sformatf("%s_last%0d", nm, rcvd), 64'(out_last), 64'(rcvd == n - 1));
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    check({nm, "_count"}, 64'(rcvd), 64'(n));
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check({nm, "_no_extra"}, 64'(extra), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    vecs[0]  = '{"basic",      32'sd100,  32'sd1073741824, 6'd31, -8'sd10,  1'b0, 8'sd40};
    vecs[1]  = '{"rnd_p3",     32'sd3,    32'sd1073741824, 6'd31, 8'sd0,    1'b0, 8'sd2};
    vecs[2]  = '{"rnd_m3",     -32'sd3,   32'sd1073741824, 6'd31, 8'sd0,    1'b0, -8'sd1};
    vecs[3]  = '{"rnd_p1",     32'sd1,    32'sd1073741824, 6'd31, 8'sd0,    1'b0, 8'sd1};
    vecs[4]  = '{"sat_hi",     32'sd1000, 32'sd1073741824, 6'd31, 8'sd0,    1'b0, 8'sd127};
    vecs[5]  = '{"sat_lo",     -32'sd1000,32'sd1073741824, 6'd31, 8'sd0,    1'b0, -8'sd128};
    vecs[6]  = '{"relu_clamp", -32'sd100, 32'sd1073741824, 6'd31, -8'sd105, 1'b1, -8'sd105};
    vecs[7]  = '{"shift0",     32'sd5,    32'sd3,          6'd0,  8'sd0,    1'b0, 8'sd15};
    vecs[8]  = '{"sat32_hi",   32'sd65536,32'sd65536,      6'd0,  8'sd0,    1'b0, 8'sd127};
    vecs[9]  = '{"sat32_lo",   -32'sd65536,32'sd65536,     6'd0,  8'sd0,    1'b0, -8'sd128};
    vecs[10] = '{"shift63",    -32'sd2147483648, -32'sd2147483648, 6'd63, 8'sd0, 1'b0, 8'sd1};
    vecs[11] = '{"relu_pass",  32'sd100,  32'sd1073741824, 6'd31, 8'sd5,    1'b1, 8'sd55};
    vecs[12] = '{"half_neg",   -32'sd3,   32'sd1,          6'd1,  8'sd0,    1'b0, -8'sd1};
    vecs[13] = '{"relu_above", 32'sd100,  32'sd1073741824, 6'd31, -8'sd105, 1'b1, -8'sd55};
    vecs[14] = '{"half_zero",  -32'sd1,   32'sd1,          6'd1,  8'sd0,    1'b0, 8'sd0};

    rst_n = 1'b0; in_valid = 1'b0; in_acc = '0; in_last = 1'b0;
    mult_scalar = '0; shift_scalar = '0; zp_out = '0; relu_en = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_out_last",  64'(out_last), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd0);
    #19 rst_n = 1'b1;

    for (int t = 0; t < NV; t++)
      send_single(vecs[t].name, vecs[t].acc, vecs[t].mult, vecs[t].shift,
                  vecs[t].zp, vecs[t].relu, vecs[t].expv);

    // Backpressure: 10 beats, out_ready 1-0-0-1
    for (int k = 0; k < 10; k++) begin
      b_mult[k] = 32'sd1073741824; b_shift[k] = 6'd31; b_zp[k] = 8'sd3; b_relu[k] = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        b_acc[k][l] = 32'(k * 16 + l * 5 - 60);
        b_exp[k][l*8 +: 8] = model(b_acc[k][l], b_mult[k], b_shift[k], b_zp[k], b_relu[k]);
      end
    end
    run_stream("bp", 10, 1'b1);

    // Layer switch: alternate LUT rows per beat
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        b_mult[k] = 32'sd1499917960; b_shift[k] = 6'd36; b_zp[k] = -8'sd105;
      end else begin
        b_mult[k] = 32'sd1254985707; b_shift[k] = 6'd32; b_zp[k] = 8'sd110;
      end
      b_relu[k] = (k == 4 || k == 5);
      for (int l = 0; l < LANES; l++) begin
        b_acc[k][l] = (l == 0) ? 32'sd16777216 : 32'(l * 700 - 2800 + k * 37);
        b_exp[k][l*8 +: 8] = model(b_acc[k][l], b_mult[k], b_shift[k], b_zp[k], b_relu[k]);
      end
    end
    run_stream("layer", 8, 1'b0);

    // Reset with beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_acc = {LANES{32'(k * 10 + 10)}};
      mult_scalar = 32'd1073741824; shift_scalar = 6'd31; zp_out = 8'd0; relu_en = 1'b0;
      in_last = (k == 3);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid",   64'(out_valid), 64'd0);
    check("rst_mid_data",    out_data, 64'd0);
    check("rst_mid_inready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);
    send_single("post_rst", 32'sd100, 32'sd1073741824, 6'd31, -8'sd10, 1'b0, 8'sd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
